// File: rtl/iob_split_pipe.sv
// iob_split_pipe: routes one master request at a time to one of N_SLAVES
// slave ports selected by a field in the address. The selected slave gets a
// one-hot valid. The response is returned with a one-cycle m_ready pulse.
// Unmapped selects and slaves that stay silent too long return ERR_DATA
// with m_err set.
//
// Handshake: the master holds m_valid and its payload stable until it sees
// m_ready. m_ready is a single-cycle pulse, and m_err/m_rdata are
// meaningful in that cycle. A slave holds off by keeping s_ready low while
// its s_valid bit is high. Only s_ready of the selected slave, sampled while
// the request is outstanding, completes the transfer.
module iob_split_pipe #(
  parameter int N_SLAVES = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int P_SLAVES = ADDR_W - 2,
  parameter int TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    sel_in;
  logic                sel_mapped;
  logic                rdy_sel;
  logic [DATA_W-1:0]   rdata_sel;

  // The select field ends one bit above P_SLAVES, so with the default
  // P_SLAVES = ADDR_W-2 a 2-bit select is the two top address bits
  // (0x4000_0000 -> slave 1, 0xC000_0000 -> select 3).
  assign sel_in     = m_addr[P_SLAVES+1 -: SEL_W];
  assign sel_mapped = (int'(sel_in) < N_SLAVES);
  assign rdy_sel    = s_ready[sel_q];
  assign rdata_sel  = s_rdata[sel_q*DATA_W +: DATA_W];

  // State and datapath registers; reset clears everything visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for slave or timeout in REQ,
  // pulse the response in RESP.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          sel_d   = sel_in;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          cnt_d   = '0;
          if (sel_mapped) begin
            state_d = ST_REQ;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // A ready in the same cycle as the timeout still counts as success.
        if (rdy_sel) begin
          rdata_d = rdata_sel;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_valid   = (state_q == ST_REQ) ? (N_SLAVES'(1) << sel_q) : '0;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign m_ready   = (state_q == ST_RESP);
  assign m_rdata   = rdata_q;
  assign m_err     = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
